jsv_usb_rst_seq: RTL

Avalon-MM slave that sequences the reset line of the external USB host controller chip. It replaces software bit-banging of a one-bit reset PIO with hardware-timed assert and settle intervals. A power-on sequence runs automatically out of reset, and software can retrigger or force the sequence at any time. Status and completion are readable by the Nios II driver before it touches the USB chip's HPI port.

---
 rtl/jsv_usb_rst_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/jsv_usb_rst_seq.sv
// Avalon-MM reset sequencer for the external USB host controller: timed assert/settle with force override.
// Optional interrupt output and CTRL.IRQEN bit when USB_RST_IRQ_EN is defined.
module jsv_usb_rst_seq #(
  parameter int ASSERT_CYCLES = 50000,
  parameter int SETTLE_CYCLES = 250000,
  parameter int CNT_W         = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        ready
`ifdef USB_RST_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_SETTLE = 2'd2,
    S_FORCE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               force_bit, force_nxt;
  logic               done, done_nxt;
  logic [7:0]         seqs;
  logic               wr, ctrl_wr, stat_wr, w1c;
  logic               go_acc, complete;
  logic               usb_rst_n_nxt, ready_nxt;

  always_comb begin
    wr        = chipselect & ~write_n;
    ctrl_wr   = wr & (address == 2'd0);
    stat_wr   = wr & (address == 2'd1);
    w1c       = stat_wr & writedata[1];
    force_nxt = ctrl_wr ? writedata[1] : force_bit;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_acc    = 1'b0;
    complete  = 1'b0;
    // FORCE level wins over everything, including a GO in the same write
    if (force_nxt) begin
      state_nxt = S_FORCE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_nxt = '0;
          if (ctrl_wr && writedata[0]) begin
            state_nxt = S_ASSERT;
            go_acc    = 1'b1;
          end
        end
        S_ASSERT: begin
          if (cnt == ASSERT_LAST) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            complete  = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_FORCE: begin
          // the force interval already served as the assert phase
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    done_nxt = done;
    if (complete) begin
      done_nxt = 1'b1;
    end else if (go_acc || w1c) begin
      done_nxt = 1'b0;
    end

    usb_rst_n_nxt = !((state_nxt == S_ASSERT) || (state_nxt == S_FORCE));
    ready_nxt     = (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_ASSERT;
      cnt       <= '0;
      force_bit <= 1'b0;
      done      <= 1'b0;
      seqs      <= 8'd0;
      usb_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      force_bit <= force_nxt;
      done      <= done_nxt;
      seqs      <= seqs + {7'd0, complete};
      usb_rst_n <= usb_rst_n_nxt;
      ready     <= ready_nxt;
    end
  end

`ifdef USB_RST_IRQ_EN
  logic irqen;
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqen <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (ctrl_wr) irqen <= writedata[2];
      irq <= done & irqen & ~(w1c & ~complete);
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:2];
`endif

  always_comb begin
    readdata = '0;
    case (address)
`ifdef USB_RST_IRQ_EN
      2'd0: readdata[2:1] = {irqen, force_bit};
`else
      2'd0: readdata[1]   = force_bit;
`endif
      2'd1: readdata[3:0] = {state, done, ~ready};
      2'd2: readdata      = 32'(cnt);
      2'd3: readdata[7:0] = seqs;
    endcase
  end

endmodule
